// File: rtl/tick_rate_ctrl.sv
// Run-time configurable slow clock/tick generator with start/stop/single-step control
// and a valid/ready half-period port that is double-buffered while the divider runs.
module tick_rate_ctrl #(
    parameter int          CNT_W        = 27,
    parameter int unsigned DEFAULT_HALF = 67108863
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             counting;
    logic             wrap;
    logic             xfer;

    // The unused encoding 11 is treated exactly like IDLE.
    assign counting  = (state == ST_RUN) || (state == ST_STEP);
    assign wrap      = counting && (count >= half_reg);
    assign xfer      = cfg_valid && !pending;
    assign cfg_ready = !pending;
    assign busy      = counting;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            half_reg <= CNT_W'(DEFAULT_HALF);
            pending  <= 1'b0;
            clk_out  <= 1'b1;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!counting) begin
                count <= '0;
                if (xfer)
                    half_reg <= cfg_half;
                if (stop)
                    state <= ST_IDLE;
                else if (start)
                    state <= ST_RUN;
                else if (step)
                    state <= ST_STEP;
                else
                    state <= ST_IDLE;
            end else if (stop) begin
                // Stop beats a coincident wrap: no toggle, level parks high, shadow lands.
                state   <= ST_IDLE;
                count   <= '0;
                clk_out <= 1'b1;
                pending <= 1'b0;
                if (xfer)
                    half_reg <= cfg_half;
                else if (pending)
                    half_reg <= shadow;
            end else if (wrap) begin
                count   <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
                if (pending)
                    half_reg <= shadow;
                if (state == ST_STEP) begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                    if (xfer)
                        half_reg <= cfg_half;
                end else begin
                    // A value accepted on the wrap edge waits for the following wrap.
                    pending <= xfer;
                end
            end else begin
                count <= count + 1'b1;
                if (xfer)
                    pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (xfer && counting)
            shadow <= cfg_half;
    end

endmodule
